gpio_multiport: RTL
===================

Name: gpio_multiport

Overview:
- Parametrised GPIO controller on the I/O SRAM bus, replacing the fixed two-port, 8-bit GPIO register file.
- Supports NUM_PORTS ports of DATA_WIDTH pins each, with per-pin direction control and input synchronisers.
- Provides atomic set/clear/toggle of output bits.
- Optionally adds edge-triggered pin-change interrupts with a single irq line to the CPU.

Parameters:
- DATA_WIDTH, 8, pins per port and bus data width.
- ADDR_WIDTH, 6, I/O address width; NUM_PORTS*8 must be <= 2**ADDR_WIDTH.
- NUM_PORTS, 2, number of GPIO ports, legal range 1..4.
- SYNC_STAGES, 2, flip-flop stages in each pin input synchroniser, legal range >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  chip select.
- we  in  1  write enable.
- oe  in  1  output enable for bus read.
- address  in  ADDR_WIDTH  register address.
- data  inout  DATA_WIDTH  bidirectional CPU data bus.
- pins  inout  NUM_PORTS*DATA_WIDTH  external pads; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- irq  out  1  pin-change interrupt request; constant 0 when GPIO_IRQ_EN is undefined.

Behaviour:
- Reset and clock: reset is synchronous and active-high; clock is clk.
- Register map: port p occupies base p*8.
  - Offset 0 PIN: read-only.
  - Offset 1 DDR: read/write.
  - Offset 2 PORT: read/write.
  - Offset 3 IFR: write-1-to-clear.
  - Offset 4 IMSK: read/write.
  - Offset 5 PSET: write-only, reads 0.
  - Offset 6 PCLR: write-only, reads 0.
  - Offset 7 PTGL: write-only, reads 0.
  - Addresses >= NUM_PORTS*8 read 0; writes to them are ignored.
- Reset values: every register, every sync stage, addr_buf and irq clear to 0. All pins are therefore inputs (high-Z) and data is high-Z.
- Bus write: when cs && we, the write takes effect at the next clk edge.
  - PSET: PORT |= data.
  - PCLR: PORT &= ~data.
  - PTGL: PORT ^= data.
  - Writes to PIN are ignored.
- Bus read: when cs && !we, address is latched into addr_buf at the clk edge. data = regfile[addr_buf] while cs && oe && !we, otherwise high-Z. Read data is valid one cycle after the address is presented.
- Pad drive: pin bit i of port p is driven to PORT[i] when DDR[i]=1, else 1'bz. The change is visible the same cycle the register updates.
- Input path: every pad bit passes through a SYNC_STAGES-deep synchroniser.
  - PIN holds the last stage for all bits, including outputs, so output pins read back through the synchroniser.
  - Pad change to PIN update latency: exactly SYNC_STAGES cycles.
- Outputs are driven from registers; there is no combinational path from pins to data.

Optional Feature:
- Macro: GPIO_IRQ_EN.
- Edge detection (defined):
  - prev_p holds the previous PIN value.
  - An edge on bit i is PIN[i] != prev_p[i] && DDR[i]==0.
  - A detected edge sets IFR[i] at the same edge on which prev_p updates.
- Startup blanking (defined):
  - After reset a counter blanks edge detection for SYNC_STAGES+1 cycles.
  - This prevents false flags from pads that are already high at reset.
  - Reset asserted mid-operation restarts the blanking counter.
- Flag clear (defined): a W1C write to IFR clears the written bits. If an edge and a W1C hit the same bit in the same cycle, set wins.
- irq (defined): irq is registered and equals OR over all ports of (IFR & IMSK). It asserts one cycle after the flag sets and deasserts one cycle after the last enabled flag is cleared or masked.
- Without the macro: IFR and IMSK read 0 and ignore writes, irq is tied 0, and no edge logic or blanking counter is built.

Test Plan:
- Reset, then read all 16 registers (NUM_PORTS=2) -> all read 0x00; all pins high-Z; irq=0.
- Write DDR0=0xF0 then PORT0=0xA5 -> pins[7:4]=4'hA, pins[3:0]=z; PIN0 reads 0xA0 (with pads[3:0] held 0) SYNC_STAGES cycles later.
- With PORT1=0x0F: write PSET1=0x30, then PCLR1=0x01, then PTGL1=0xFF -> PORT1 reads back 0x3F, then 0x3E, then 0xC1; PSET1 reads 0.
- Drive pins[8+2] 0->1 with DDR1=0 -> PIN1[2]=1 exactly 2 cycles later. Then write PIN1=0xFF -> PIN1 is unchanged.
- GPIO_IRQ_EN defined: IMSK0=0x01, pad0 bit0 rises -> IFR0 reads 0x01 and irq=1 one cycle after the flag sets. Write IFR0=0x01 -> irq=0 one cycle later. Pad held high through reset -> IFR0 stays 0.
- GPIO_IRQ_EN defined: an edge on bit0 and a W1C of IFR0=0x01 in the same cycle -> IFR0[0] remains 1. Read of address 0x20 -> 0x00.

Source files
------------

// File: rtl/gpio_multiport.sv
// GPIO controller on the I/O SRAM bus: NUM_PORTS x DATA_WIDTH pins with direction, set/clear/toggle, synchronised inputs.
// Bus reads return data one cycle after the address is presented; PIN trails the pads by SYNC_STAGES cycles.
// Defining GPIO_IRQ_EN adds pin-change flags (IFR), masks (IMSK), startup blanking and a registered irq.
module gpio_multiport #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 6,
  parameter int NUM_PORTS   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cs,
  input  logic                              we,
  input  logic                              oe,
  input  logic [ADDR_WIDTH-1:0]             address,
  inout  wire  [DATA_WIDTH-1:0]             data,
  inout  wire  [NUM_PORTS*DATA_WIDTH-1:0]   pins,
  output logic                              irq
);

  localparam int PW = ADDR_WIDTH - 3;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t                 ddr    [NUM_PORTS];
  word_t                 port_r [NUM_PORTS];
  word_t                 sync_r [NUM_PORTS][SYNC_STAGES];
  word_t                 pin_v  [NUM_PORTS];
  word_t                 rdata;
  logic [ADDR_WIDTH-1:0] addr_buf;
  logic                  wr_en;

  assign wr_en = cs && we;

  // PIN is the last synchroniser stage of each port
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      pin_v[p] = sync_r[p][SYNC_STAGES-1];
    end
  end

  // Direction and output registers, including the atomic set/clear/toggle aliases
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        ddr[p]    <= '0;
        port_r[p] <= '0;
      end
    end else if (wr_en) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (address[ADDR_WIDTH-1:3] == PW'(p)) begin
          case (address[2:0])
            3'd1:    ddr[p]    <= data;
            3'd2:    port_r[p] <= data;
            3'd5:    port_r[p] <= port_r[p] | data;
            3'd6:    port_r[p] <= port_r[p] & ~data;
            3'd7:    port_r[p] <= port_r[p] ^ data;
            default: ;
          endcase
        end
      end
    end
  end

  // Input synchronisers sample every pad bit, output pins included
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int s = 0; s < SYNC_STAGES; s++) begin
          sync_r[p][s] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        sync_r[p][0] <= pins[p*DATA_WIDTH +: DATA_WIDTH];
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_r[p][s] <= sync_r[p][s-1];
        end
      end
    end
  end

  // Read address is captured so read data always comes from registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_buf <= '0;
    end else if (cs && !we) begin
      addr_buf <= address;
    end
  end

`ifdef GPIO_IRQ_EN
  localparam int BW = $clog2(SYNC_STAGES + 2);

  word_t          prev_p [NUM_PORTS];
  word_t          ifr    [NUM_PORTS];
  word_t          imsk   [NUM_PORTS];
  word_t          edge_v [NUM_PORTS];
  logic [BW-1:0]  blank_cnt;
  logic           armed;
  logic           irq_next;

  assign armed = (blank_cnt == BW'(SYNC_STAGES + 1));

  // Blanking counter holds off edge detection until the synchronisers have filled after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_cnt <= '0;
    end else if (!armed) begin
      blank_cnt <= blank_cnt + 1'b1;
    end
  end

  // Edge detection on input-direction pins and the OR-reduced interrupt request
  always_comb begin
    irq_next = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      edge_v[p] = armed ? ((pin_v[p] ^ prev_p[p]) & ~ddr[p]) : '0;
      irq_next  = irq_next | (|(ifr[p] & imsk[p]));
    end
  end

  // Flag, mask and previous-pin registers; a new edge beats a same-cycle W1C
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        prev_p[p] <= '0;
        ifr[p]    <= '0;
        imsk[p]   <= '0;
      end
    end else begin
      irq <= irq_next;
      for (int p = 0; p < NUM_PORTS; p++) begin
        prev_p[p] <= pin_v[p];
        if (wr_en && address[ADDR_WIDTH-1:3] == PW'(p) && address[2:0] == 3'd3) begin
          ifr[p] <= (ifr[p] & ~data) | edge_v[p];
        end else begin
          ifr[p] <= ifr[p] | edge_v[p];
        end
        if (wr_en && address[ADDR_WIDTH-1:3] == PW'(p) && address[2:0] == 3'd4) begin
          imsk[p] <= data;
        end
      end
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux; unmapped addresses match no port and return 0
  always_comb begin
    rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (addr_buf[ADDR_WIDTH-1:3] == PW'(p)) begin
        case (addr_buf[2:0])
          3'd0:    rdata = pin_v[p];
          3'd1:    rdata = ddr[p];
          3'd2:    rdata = port_r[p];
`ifdef GPIO_IRQ_EN
          3'd3:    rdata = ifr[p];
          3'd4:    rdata = imsk[p];
`endif
          default: rdata = '0;
        endcase
      end
    end
  end

  assign data = (cs && oe && !we) ? rdata : 'z;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pin
      assign pins[p*DATA_WIDTH + i] = ddr[p][i] ? port_r[p][i] : 1'bz;
    end
  end

endmodule
